// File: rtl/sw_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press pulse and long-press detect per channel.
// Define SW_AUTO_REPEAT_EN to add auto-repeat press pulses while a switch is held in long-press.
module sw_conditioner #(
    parameter int NUM_SW        = 5,
    parameter bit SW_ACTIVE_LOW = 1'b1,
    parameter int DEB_CNT       = 50000,
    parameter int LONG_CNT      = 50000000,
    parameter int REPEAT_CNT    = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] i_sw_raw,
    output logic [NUM_SW-1:0] o_sw_level,
    output logic [NUM_SW-1:0] o_sw_pulse,
    output logic [NUM_SW-1:0] o_long,
    output logic [NUM_SW-1:0] o_long_pulse
);

    localparam int DEB_W  = $clog2(DEB_CNT);
    localparam int HOLD_W = $clog2(LONG_CNT);
`ifdef SW_AUTO_REPEAT_EN
    localparam int RPT_W  = $clog2(REPEAT_CNT);
`endif

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [NUM_SW-1:0] raw_act;
    logic [NUM_SW-1:0] sync1_q;
    logic [NUM_SW-1:0] sync2_q;

    assign raw_act = SW_ACTIVE_LOW ? ~i_sw_raw : i_sw_raw;

    // Synchronizer resets to the released (0) value so a held switch looks like a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_act;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        logic [DEB_W-1:0]  deb_q, deb_d;
        logic              lvl_q, lvl_d;
        logic              rise, fall;
        state_t            st_q, st_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              pulse_q, pulse_d;
        logic              long_q, long_d;
        logic              lpulse_q, lpulse_d;
`ifdef SW_AUTO_REPEAT_EN
        logic [RPT_W-1:0]  rpt_q, rpt_d;
`endif

        // Any matching sample clears the count, so only an unbroken run of DEB_CNT mismatches flips the level.
        always_comb begin
            deb_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[i] != lvl_q) begin
                if (deb_q == DEB_W'(DEB_CNT - 1)) begin
                    lvl_d = ~lvl_q;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
        end

        assign rise = lvl_d & ~lvl_q;
        assign fall = ~lvl_d & lvl_q;

        always_comb begin
            st_d     = st_q;
            hold_d   = hold_q;
            long_d   = long_q;
            lpulse_d = 1'b0;
            pulse_d  = rise;
`ifdef SW_AUTO_REPEAT_EN
            rpt_d    = rpt_q;
`endif
            if (fall) begin
                st_d   = IDLE;
                hold_d = '0;
                long_d = 1'b0;
`ifdef SW_AUTO_REPEAT_EN
                rpt_d  = '0;
`endif
            end else begin
                case (st_q)
                    IDLE: begin
                        if (rise) begin
                            st_d   = HELD;
                            hold_d = '0;
                        end
                    end
                    HELD: begin
                        if (hold_q == HOLD_W'(LONG_CNT - 1)) begin
                            st_d     = LONG;
                            long_d   = 1'b1;
                            lpulse_d = 1'b1;
`ifdef SW_AUTO_REPEAT_EN
                            rpt_d    = '0;
                            pulse_d  = 1'b1;
`endif
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    LONG: begin
`ifdef SW_AUTO_REPEAT_EN
                        if (rpt_q == RPT_W'(REPEAT_CNT - 1)) begin
                            rpt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            rpt_d = rpt_q + RPT_W'(1);
                        end
`endif
                    end
                    default: begin
                        st_d   = IDLE;
                        hold_d = '0;
                        long_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_q    <= '0;
                lvl_q    <= 1'b0;
                st_q     <= IDLE;
                hold_q   <= '0;
                pulse_q  <= 1'b0;
                long_q   <= 1'b0;
                lpulse_q <= 1'b0;
`ifdef SW_AUTO_REPEAT_EN
                rpt_q    <= '0;
`endif
            end else begin
                deb_q    <= deb_d;
                lvl_q    <= lvl_d;
                st_q     <= st_d;
                hold_q   <= hold_d;
                pulse_q  <= pulse_d;
                long_q   <= long_d;
                lpulse_q <= lpulse_d;
`ifdef SW_AUTO_REPEAT_EN
                rpt_q    <= rpt_d;
`endif
            end
        end

        assign o_sw_level[i]   = lvl_q;
        assign o_sw_pulse[i]   = pulse_q;
        assign o_long[i]       = long_q;
        assign o_long_pulse[i] = lpulse_q;
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_sw_conditioner;

    localparam int NSW  = 5;
    localparam int DEB  = 4;
    localparam int LNG  = 20;
    localparam int RPT  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NSW-1:0] i_sw_raw;
    logic [NSW-1:0] o_sw_level, o_sw_pulse, o_long, o_long_pulse;

    int checks   = 0;
    int failures = 0;

    sw_conditioner #(
        .NUM_SW(NSW), .SW_ACTIVE_LOW(1'b1), .DEB_CNT(DEB), .LONG_CNT(LNG), .REPEAT_CNT(RPT)
    ) dut (
        .clk(clk), .rst(rst), .i_sw_raw(i_sw_raw),
        .o_sw_level(o_sw_level), .o_sw_pulse(o_sw_pulse),
        .o_long(o_long), .o_long_pulse(o_long_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a debounced level follows the pressed value once the last DEB samples seen
    // (raw delayed by two edges) all agree and differ from it; everything else follows
    // from the number of edges elapsed since the level rose.
    bit [NSW-1:0] m_lvl, m_pulse, m_long, m_lp;
    bit           da[NSW], db[NSW], prev_s[NSW];
    int           streak[NSW], age[NSW];

    always @(posedge clk) begin
        if (rst) begin
            m_lvl = '0; m_pulse = '0; m_long = '0; m_lp = '0;
            for (int c = 0; c < NSW; c++) begin
                da[c] = 0; db[c] = 0; prev_s[c] = 0; streak[c] = 0; age[c] = 0;
            end
        end else begin
            for (int c = 0; c < NSW; c++) begin
                bit p, s, rise, rep;
                p = ~i_sw_raw[c];
                s = db[c];
                db[c] = da[c];
                da[c] = p;
                if (s == prev_s[c]) streak[c]++; else streak[c] = 1;
                prev_s[c] = s;
                rise = 0;
                if (s != m_lvl[c] && streak[c] >= DEB) begin
                    m_lvl[c] = s;
                    rise = s;
                end
                if (rise) age[c] = 0;
                else if (m_lvl[c]) age[c]++;
                rep = 0;
`ifdef SW_AUTO_REPEAT_EN
                rep = m_lvl[c] && age[c] >= LNG && ((age[c] - LNG) % RPT) == 0;
`endif
                m_pulse[c] = rise | rep;
                m_long[c]  = m_lvl[c] && age[c] >= LNG;
                m_lp[c]    = m_lvl[c] && age[c] == LNG;
            end
        end
    end

    always @(negedge clk) begin
        chk("level", int'(o_sw_level),   rst ? 0 : int'(m_lvl));
        chk("pulse", int'(o_sw_pulse),   rst ? 0 : int'(m_pulse));
        chk("long",  int'(o_long),       rst ? 0 : int'(m_long));
        chk("lpuls", int'(o_long_pulse), rst ? 0 : int'(m_lp));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, at, nb, lpoff, nlp, longseen;
        logic [NSW-1:0] val;
        int offs[$];
`ifdef SW_AUTO_REPEAT_EN
        int exp_offs[$] = '{0, 20, 28, 36, 44};
`else
        int exp_offs[$] = '{0};
`endif
        rst = 1'b1;
        i_sw_raw = '1;
        repeat (3) tick();
        rst = 1'b0;

        // Test 1: reset mid-press, then re-detection after deassertion.
        i_sw_raw[0] = 1'b0;
        repeat (8) tick();
        chk("t1_pre_level", int'(o_sw_level[0]), 1);
        #3 rst = 1'b1;
        #1;
        chk("t1_rst_level", int'(o_sw_level), 0);
        chk("t1_rst_pulse", int'(o_sw_pulse), 0);
        chk("t1_rst_long",  int'(o_long), 0);
        chk("t1_rst_lp",    int'(o_long_pulse), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("t1_e5_level", int'(o_sw_level[0]), 0);
            if (k == 6) begin
                chk("t1_e6_level", int'(o_sw_level[0]), 1);
                chk("t1_e6_pulse", int'(o_sw_pulse[0]), 1);
            end
            if (k == 7) chk("t1_e7_pulse", int'(o_sw_pulse[0]), 0);
        end
        i_sw_raw[0] = 1'b1;
        repeat (10) tick();

        // Test 2: bounce on sw1, then stable press.
        nb = 0;
        for (int seg = 0; seg < 10; seg++) begin
            i_sw_raw[1] = seg[0];
            repeat (2) begin
                tick();
                if (o_sw_pulse[1]) nb++;
            end
        end
        chk("t2_bounce_pulses", nb, 0);
        i_sw_raw[1] = 1'b0;
        n = 0; at = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_sw_pulse[1]) begin n++; at = k; end
        end
        chk("t2_npulse", n, 1);
        chk("t2_pulse_edge", at, 6);
        i_sw_raw[1] = 1'b1;
        repeat (10) tick();

        // Test 3: long press on sw2.
        i_sw_raw[2] = 1'b0;
        repeat (6) tick();
        chk("t3_rise", int'(o_sw_level[2]), 1);
        nlp = 0; lpoff = -1;
        for (int off = 1; off <= 40; off++) begin
            tick();
            if (o_long_pulse[2]) begin nlp++; lpoff = off; end
            if (off == 19) chk("t3_long_off19", int'(o_long[2]), 0);
            if (off == 20) chk("t3_long_off20", int'(o_long[2]), 1);
        end
        chk("t3_nlp", nlp, 1);
        chk("t3_lp_off", lpoff, 20);
        i_sw_raw[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t3_long_release", int'(o_long[2]), (k < 6) ? 1 : 0);
        end
        repeat (4) tick();

        // Test 4: held sw3, press/repeat pulse offsets from level rise.
        i_sw_raw[3] = 1'b0;
        repeat (6) tick();
        if (o_sw_pulse[3]) offs.push_back(0);
        for (int off = 1; off <= 55; off++) begin
            if (off == 46) i_sw_raw[3] = 1'b1;
            tick();
            if (o_sw_pulse[3]) offs.push_back(off);
        end
        chk("t4_count", offs.size(), exp_offs.size());
        for (int j = 0; j < exp_offs.size(); j++)
            chk("t4_offset", (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
        repeat (4) tick();

        // Test 5: simultaneous press on sw0 and sw4.
        i_sw_raw[0] = 1'b0;
        i_sw_raw[4] = 1'b0;
        n = 0; at = -1; val = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_sw_pulse != '0) begin n++; at = k; val = o_sw_pulse; end
        end
        chk("t5_ncycles", n, 1);
        chk("t5_edge", at, 6);
        chk("t5_vector", int'(val), 5'b10001);
        i_sw_raw = '1;
        repeat (10) tick();

        // Test 6: short press, then a second press must time its long press from scratch.
        i_sw_raw[1] = 1'b0;
        n = 0; longseen = 0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 11) i_sw_raw[1] = 1'b1;
            tick();
            if (o_sw_pulse[1]) n++;
            if (o_long[1] || o_long_pulse[1]) longseen++;
        end
        chk("t6_npulse", n, 1);
        chk("t6_long_seen", longseen, 0);
        chk("t6_level_idle", int'(o_sw_level[1]), 0);
        i_sw_raw[1] = 1'b0;
        repeat (6) tick();
        lpoff = -1;
        for (int off = 1; off <= 22; off++) begin
            tick();
            if (o_long_pulse[1]) lpoff = off;
        end
        chk("t6_repress_lp_off", lpoff, 20);
        i_sw_raw[1] = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
